// File: rtl/conv1_kernel_scheduler.sv
// Conv-1 scheduler: walks every window position for each 3x3 kernel, does a 9-tap MAC per cycle,
// applies ReLU/shift/saturate and streams results over valid/ready with backpressure.
module conv1_kernel_scheduler #(
  parameter int unsigned IMG_DIM   = 8,
  parameter int unsigned N_KERNELS = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 21,
  parameter int unsigned OUT_SHIFT = 4,
  localparam int unsigned AW = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1,
  localparam int unsigned KW = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [N_KERNELS*9*DATA_W-1:0] weights,
  output logic [AW-1:0]                 win_row,
  output logic [AW-1:0]                 win_col,
  output logic [KW-1:0]                 kern_sel,
  input  logic [9*DATA_W-1:0]           win_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [KW-1:0]                 out_kern,
  output logic [AW-1:0]                 out_row,
  output logic [AW-1:0]                 out_col,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned WW = N_KERNELS * 9 * DATA_W;
  localparam logic [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [1:0]        state_q, state_d;
  logic [WW-1:0]     weights_q, weights_d;
  logic [KW-1:0]     kern_q, kern_d;
  logic [AW-1:0]     row_q, row_d;
  logic [AW-1:0]     col_q, col_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [KW-1:0]     out_kern_q, out_kern_d;
  logic [AW-1:0]     out_row_q, out_row_d;
  logic [AW-1:0]     out_col_q, out_col_d;

  logic                    advance;
  logic                    pos_last;
  logic                    col_end;
  logic                    row_end;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]        shr;
  logic [DATA_W-1:0]       result;

  assign advance  = (state_q == StRun) && (!out_valid_q || out_ready);
  assign col_end  = (col_q == AW'(IMG_DIM - 1));
  assign row_end  = (row_q == AW'(IMG_DIM - 1));
  assign pos_last = (kern_q == KW'(N_KERNELS - 1)) && row_end && col_end;

  // Pixels are unsigned, weights signed: zero-extend one, sign-extend the other.
  always_comb begin
    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] wt;
    acc = '0;
    for (int t = 0; t < 9; t++) begin
      pix = win_data[t*DATA_W +: DATA_W];
      wt  = weights_q[(int'(kern_q) * 9 + t) * DATA_W +: DATA_W];
      acc = acc + $signed({{(ACC_W-DATA_W){1'b0}}, pix})
                * $signed({{(ACC_W-DATA_W){wt[DATA_W-1]}}, wt});
    end
    if (acc[ACC_W-1]) begin
      shr = '0;
    end else begin
      shr = unsigned'(acc >>> OUT_SHIFT);
    end
    result = (shr > SatMax) ? '1 : shr[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    weights_d   = weights_q;
    kern_d      = kern_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_kern_d  = out_kern_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          weights_d = weights;
          kern_d    = '0;
          row_d     = '0;
          col_d     = '0;
        end
      end
      StRun: begin
        if (advance) begin
          out_valid_d = 1'b1;
          out_data_d  = result;
          out_kern_d  = kern_q;
          out_row_d   = row_q;
          out_col_d   = col_q;
          out_last_d  = pos_last;
          // Counters park on the final position; the next start clears them.
          if (pos_last) begin
            state_d = StDrain;
          end else if (col_end) begin
            col_d = '0;
            if (row_end) begin
              row_d  = '0;
              kern_d = kern_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      weights_q   <= '0;
      kern_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_kern_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      weights_q   <= weights_d;
      kern_q      <= kern_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_kern_q  <= out_kern_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign win_row   = row_q;
  assign win_col   = col_q;
  assign kern_sel  = kern_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_kern  = out_kern_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_conv1_kernel_scheduler.sv
// Directed bench for conv1_kernel_scheduler: two instances (OUT_SHIFT 0 and 4) fed by a
// zero-padded uniform-image extractor model; results checked beat by beat against a MAC model.
module tb_conv1_kernel_scheduler;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         sel;
  logic         out_ready;
  logic [215:0] weights;
  logic signed [7:0] wcur [3][9];
  logic signed [7:0] wexp [3][9];
  logic [7:0]   pix_a, pix_b;
  int           n_checks, n_errors;
  int           last_hs;
  int           got [192];

  logic       start_a, start_b;
  logic [2:0] win_row_a, win_col_a, win_row_b, win_col_b;
  logic [1:0] kern_sel_a, kern_sel_b;
  logic [71:0] win_data_a, win_data_b;
  logic       out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic [7:0] out_data_a, out_data_b;
  logic [1:0] out_kern_a, out_kern_b;
  logic [2:0] out_row_a, out_row_b, out_col_a, out_col_b;
  logic       busy_a, busy_b, done_a, done_b;

  logic       o_valid, o_last, o_busy, o_done;
  logic [7:0] o_data;
  logic [1:0] o_kern, o_kern_sel;
  logic [2:0] o_row, o_col, o_win_row, o_win_col;
  logic [27:0] o_all;

  conv1_kernel_scheduler #(.IMG_DIM(8), .N_KERNELS(3), .DATA_W(8), .ACC_W(21), .OUT_SHIFT(0))
  dut_a (.clk(clk), .reset_n(reset_n), .start(start_a), .weights(weights),
         .win_row(win_row_a), .win_col(win_col_a), .kern_sel(kern_sel_a), .win_data(win_data_a),
         .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
         .out_kern(out_kern_a), .out_row(out_row_a), .out_col(out_col_a),
         .out_last(out_last_a), .busy(busy_a), .done(done_a));

  conv1_kernel_scheduler #(.IMG_DIM(8), .N_KERNELS(3), .DATA_W(8), .ACC_W(21), .OUT_SHIFT(4))
  dut_b (.clk(clk), .reset_n(reset_n), .start(start_b), .weights(weights),
         .win_row(win_row_b), .win_col(win_col_b), .kern_sel(kern_sel_b), .win_data(win_data_b),
         .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
         .out_kern(out_kern_b), .out_row(out_row_b), .out_col(out_col_b),
         .out_last(out_last_b), .busy(busy_b), .done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit inb(input int v);
    return (v >= 0) && (v < 8);
  endfunction

  function automatic logic [71:0] win_of(input logic [2:0] row, input logic [2:0] col,
                                         input logic [7:0] pv);
    win_of = '0;
    for (int t = 0; t < 9; t++)
      if (inb(int'(row) - 1 + t / 3) && inb(int'(col) - 1 + t % 3)) win_of[t*8 +: 8] = pv;
  endfunction

  assign win_data_a = win_of(win_row_a, win_col_a, pix_a);
  assign win_data_b = win_of(win_row_b, win_col_b, pix_b);
  assign start_a    = start & ~sel;
  assign start_b    = start & sel;

  always_comb begin
    weights = '0;
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < 9; t++) weights[(k*9+t)*8 +: 8] = wcur[k][t];
  end

  assign o_valid    = sel ? out_valid_b : out_valid_a;
  assign o_last     = sel ? out_last_b  : out_last_a;
  assign o_busy     = sel ? busy_b      : busy_a;
  assign o_done     = sel ? done_b      : done_a;
  assign o_data     = sel ? out_data_b  : out_data_a;
  assign o_kern     = sel ? out_kern_b  : out_kern_a;
  assign o_row      = sel ? out_row_b   : out_row_a;
  assign o_col      = sel ? out_col_b   : out_col_a;
  assign o_win_row  = sel ? win_row_b   : win_row_a;
  assign o_win_col  = sel ? win_col_b   : win_col_a;
  assign o_kern_sel = sel ? kern_sel_b  : kern_sel_a;
  assign o_all = {o_valid, o_busy, o_done, o_data, o_kern, o_row, o_col, o_last,
                  o_win_row, o_win_col, o_kern_sel};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Weight sets: 0 = +1 / -1 / centre-only, 1 = +127 / centre -1 / centre +1, 2 = asymmetric.
  task automatic set_w(input int kind);
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < 9; t++) begin
        if (kind == 0)
          wcur[k][t] = (k == 0) ? 8'sd1 : (k == 1) ? -8'sd1 : ((t == 4) ? 8'sd1 : 8'sd0);
        else if (kind == 1)
          wcur[k][t] = (k == 0) ? 8'sd127 : (t != 4) ? 8'sd0 : (k == 1) ? -8'sd1 : 8'sd1;
        else
          wcur[k][t] = 8'sd0;
      end
    if (kind == 2) begin
      wcur[0][1] = 8'sd5;  wcur[0][8] = 8'sd2;  wcur[0][6] = -8'sd1;
      wcur[1][3] = 8'sd7;  wcur[1][5] = -8'sd2;
      wcur[2][0] = 8'sd3;  wcur[2][2] = 8'sd4;  wcur[2][7] = 8'sd1;
    end
  endtask

  function automatic int model(input int k, input int r, input int c, input int pv,
                               input int shift);
    int acc = 0;
    for (int t = 0; t < 9; t++)
      if (inb(r - 1 + t / 3) && inb(c - 1 + t % 3)) acc += pv * int'(wexp[k][t]);
    if (acc < 0) acc = 0;
    acc = acc >>> shift;
    return (acc > 255) ? 255 : acc;
  endfunction

  // One run on the selected instance; optional stall, mid-run start/weight change, or abort.
  task automatic run_check(input string nm, input int stall_at, input int disturb_at,
                           input int abort_at);
    int beats = 0;
    int final_hs = 0;
    int stall_cnt = 0;
    int idx;
    int pv = sel ? int'(pix_b) : int'(pix_a);
    int shift = sel ? 4 : 0;
    bit ended = 0, stalled_prev = 0, stall_used = 0, dist_used = 0, aborted = 0;
    logic [24:0] snap = '0;
    logic [24:0] cur;
    out_ready = 1'b1;
    wexp = wcur;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 300 && !ended; cyc++) begin
      @(negedge clk);
      cur = o_all[24:0];
      chk({nm, "_valid"}, o_valid, (cyc >= 2) && (final_hs == 0));
      chk({nm, "_done"}, o_done, (final_hs != 0) && (cyc == final_hs + 1));
      chk({nm, "_busy"}, o_busy, final_hs == 0);
      if (final_hs != 0) begin
        ended = 1;
      end else begin
        idx = beats + (o_valid ? 1 : 0);
        if (idx < 192) chk({nm, "_win_pos"}, {o_kern_sel, o_win_row, o_win_col}, idx);
        if (stalled_prev) chk({nm, "_freeze"}, cur, snap);
        if (o_valid && out_ready) begin
          got[beats] = int'(o_data);
          chk({nm, "_data"}, o_data, model(beats / 64, (beats / 8) % 8, beats % 8, pv, shift));
          chk({nm, "_tags"}, {o_kern, o_row, o_col}, beats);
          chk({nm, "_last"}, o_last, beats == 191);
          beats++;
          if (beats == 192) final_hs = cyc;
        end
        stalled_prev = o_valid && !out_ready;
        snap = cur;
        @(posedge clk); #1;
        start = 1'b0;
        if (stall_cnt > 0) stall_cnt--;
        if (beats == stall_at && !stall_used) begin
          stall_used = 1;
          stall_cnt  = 5;
        end
        out_ready = (stall_cnt == 0);
        if (beats == disturb_at && !dist_used) begin
          dist_used = 1;
          start = 1'b1;
          set_w(0);
        end
        if (beats == abort_at) begin
          reset_n = 1'b0;
          #1;
          chk({nm, "_abort_zero"}, o_all, 0);
          aborted = 1;
          ended = 1;
        end
      end
    end
    if (!aborted) begin
      chk({nm, "_completed"}, final_hs != 0, 1);
      chk({nm, "_beats"}, beats, 192);
    end else begin
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
    last_hs = final_hs;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    sel = 1'b0;
    out_ready = 1'b1;
    pix_a = 8'd1;
    pix_b = 8'd255;
    set_w(0);
    #12;
    chk("reset_outputs_a", o_all, 0);
    sel = 1'b1;
    #1;
    chk("reset_outputs_b", o_all, 0);
    sel = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", o_all, 0);

    // All-ones image, OUT_SHIFT 0; also full-throughput timing.
    set_w(0);
    run_check("t1", -1, -1, -1);
    chk("t1_k0_corner", got[0], 4);
    chk("t1_k0_edge", got[1], 6);
    chk("t1_k0_interior", got[9], 9);
    chk("t1_k1_relu", got[73], 0);
    chk("t1_k2_centre", got[128], 1);
    chk("t3_last_handshake_cycle", last_hs, 193);

    // Saturation and shift on the OUT_SHIFT=4 instance, image all 255.
    sel = 1'b1;
    set_w(1);
    run_check("t2", -1, -1, -1);
    chk("t2_interior_sat", got[9], 255);
    chk("t2_corner_sat", got[0], 255);
    chk("t2_k1_relu", got[73], 0);
    chk("t2_k2_shift", got[137], 15);
    sel = 1'b0;

    // Backpressure: five stalled cycles.
    set_w(0);
    run_check("t4", 10, -1, -1);
    chk("t4_last_handshake_cycle", last_hs, 198);

    // Abort by reset at beat 50, then a clean restart.
    run_check("t5_abort", -1, -1, 50);
    chk("t5_idle_after_release", o_all, 0);
    run_check("t5_restart", -1, -1, -1);
    chk("t5_last_handshake_cycle", last_hs, 193);

    // Asymmetric weights; start pulse and weight change mid-run must be ignored.
    set_w(2);
    run_check("t6", -1, 20, -1);
    chk("t6_k0_00", got[0], 2);
    chk("t6_k0_11", got[9], 6);
    chk("t6_k0_70", got[56], 5);
    chk("t6_k1_00", got[64], 0);
    chk("t6_k1_07", got[71], 7);
    chk("t6_k2_00", got[128], 1);
    chk("t6_k2_11", got[137], 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
